// File: rtl/dct_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dct_pkg                                                              |
// | Shared constants, width helper and sequencer state for the MFCC DCT. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dct_pkg;

  localparam int NUM_MFCC        = 13;
  localparam int NUM_FILTERS     = 26;
  localparam int DATA_WIDTH      = 16;
  localparam int COEFF_WIDTH     = 16;
  localparam int COEFF_FRAC_BITS = 14;

  // Keeps a single-entry index space at one bit instead of zero.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int FILT_IDX_W  = clog2_min1(NUM_FILTERS);
  localparam int COEF_ADDR_W = clog2_min1(NUM_MFCC * NUM_FILTERS);
  localparam int RES_IDX_W   = clog2_min1(NUM_MFCC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dct_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dct_tag_pipe                                                         |
// | DEPTH-stage delay line for the MAC tag bundle, synchronous clear.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dct_tag_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/dct_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dct_sequencer                                                        |
// | Walks (k, m) pairs for a shared-MAC DCT-II and hands off the vector. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dct_sequencer #(
  parameter int NUM_MFCC    = dct_pkg::NUM_MFCC,
  parameter int NUM_FILTERS = dct_pkg::NUM_FILTERS,
  parameter int ROM_LATENCY = 1,
  localparam int FILT_W = dct_pkg::clog2_min1(NUM_FILTERS),
  localparam int ADDR_W = dct_pkg::clog2_min1(NUM_MFCC * NUM_FILTERS),
  localparam int RES_W  = dct_pkg::clog2_min1(NUM_MFCC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              log_valid,
  output logic              log_ack,
  output logic [FILT_W-1:0] filt_idx,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              res_we,
  output logic [RES_W-1:0]  res_idx,
  output logic              mfcc_valid,
  input  logic              mfcc_ready,
  output logic              busy
);

  import dct_pkg::*;

  localparam int TAG_W = RES_W + 3;
  localparam logic [FILT_W-1:0] c_m_last = FILT_W'(NUM_FILTERS - 1);
  localparam logic [RES_W-1:0]  c_k_last = RES_W'(NUM_MFCC - 1);

  seq_state_t        r_state, w_state_nxt;
  logic [FILT_W-1:0] r_m, w_m_nxt;
  logic [RES_W-1:0]  r_k, w_k_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              w_issue;
  logic              r_res_we;
  logic [RES_W-1:0]  r_res_idx;

  logic [TAG_W-1:0]  w_tag_in, w_tag_out;
  logic              w_d_valid, w_d_first, w_d_last;
  logic [RES_W-1:0]  w_d_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_m       <= '0;
      r_k       <= '0;
      r_addr    <= '0;
      r_res_we  <= 1'b0;
      r_res_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_m       <= w_m_nxt;
      r_k       <= w_k_nxt;
      r_addr    <= w_addr_nxt;
      r_res_we  <= w_d_valid & w_d_last;
      r_res_idx <= (w_d_valid & w_d_last) ? w_d_k : '0;
    end
  end

  // Counters sit at zero outside RUN, so the address outputs need no gating.
  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_k_nxt     = r_k;
    w_addr_nxt  = r_addr;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_m_nxt    = '0;
        w_k_nxt    = '0;
        w_addr_nxt = '0;
        if (log_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_issue    = 1'b1;
        w_addr_nxt = r_addr + 1'b1;
        if (r_m == c_m_last) begin
          w_m_nxt = '0;
          w_k_nxt = r_k + 1'b1;
          if (r_k == c_k_last) begin
            w_state_nxt = ST_DRAIN;
            w_k_nxt     = '0;
            w_addr_nxt  = '0;
          end
        end else begin
          w_m_nxt = r_m + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_res_we && (r_res_idx == c_k_last)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (mfcc_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_tag_in = {w_issue,
                     w_issue & (r_m == '0),
                     w_issue & (r_m == c_m_last),
                     w_issue ? r_k : '0};

  dct_tag_pipe #(
    .WIDTH (TAG_W),
    .DEPTH (ROM_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (w_tag_in),
    .dout (w_tag_out)
  );

  assign {w_d_valid, w_d_first, w_d_last, w_d_k} = w_tag_out;

  assign filt_idx   = r_m;
  assign coef_addr  = r_addr;
  assign mac_en     = w_d_valid;
  assign mac_clr    = w_d_valid & w_d_first;
  assign log_ack    = w_d_valid & w_d_last & (w_d_k == c_k_last);
  assign res_we     = r_res_we;
  assign res_idx    = r_res_idx;
  assign mfcc_valid = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dct_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dct_sequencer                                                     |
// | Cycle-count reference model for two sequencer configurations.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dct_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic log_valid = 1'b0;
  logic mfcc_ready = 1'b1;

  always #5 clk = ~clk;

  // Configuration A: defaults (13 x 26, latency 1)
  logic       a_log_ack, a_mac_en, a_mac_clr, a_res_we, a_mfcc_valid, a_busy;
  logic [4:0] a_filt_idx;
  logic [8:0] a_coef_addr;
  logic [3:0] a_res_idx;

  // Configuration B: 4 x 1, latency 3
  logic       b_log_ack, b_mac_en, b_mac_clr, b_res_we, b_mfcc_valid, b_busy;
  logic [0:0] b_filt_idx;
  logic [1:0] b_coef_addr;
  logic [1:0] b_res_idx;

  dct_sequencer dut_a (
    .clk(clk), .rst(rst), .log_valid(log_valid), .log_ack(a_log_ack),
    .filt_idx(a_filt_idx), .coef_addr(a_coef_addr), .mac_en(a_mac_en),
    .mac_clr(a_mac_clr), .res_we(a_res_we), .res_idx(a_res_idx),
    .mfcc_valid(a_mfcc_valid), .mfcc_ready(mfcc_ready), .busy(a_busy)
  );

  dct_sequencer #(.NUM_MFCC(4), .NUM_FILTERS(1), .ROM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .log_valid(log_valid), .log_ack(b_log_ack),
    .filt_idx(b_filt_idx), .coef_addr(b_coef_addr), .mac_en(b_mac_en),
    .mac_clr(b_mac_clr), .res_we(b_res_we), .res_idx(b_res_idx),
    .mfcc_valid(b_mfcc_valid), .mfcc_ready(mfcc_ready), .busy(b_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic ack; int filt; int addr; logic en; logic clr;
    logic we; int idx; logic valid; logic busy;
  } exp_t;

  // t = 0 while idle, otherwise cycles since log_valid was taken in IDLE.
  function automatic int step(input int t, input int nf, input int nm, input int lat,
                              input logic r, input logic lv, input logic rdy);
    int t_done = nf * nm + lat + 2;
    if (r) return 0;
    if (t == 0) return lv ? 1 : 0;
    if (t < t_done) return t + 1;
    return rdy ? 0 : t_done;
  endfunction

  function automatic exp_t model(input int t, input int nf, input int nm, input int lat);
    exp_t e;
    int total = nf * nm;
    int u = t - lat - 1;
    e = '0;
    e.busy = (t != 0);
    if (t >= 1 && t <= total) begin
      e.filt = (t - 1) % nf;
      e.addr = t - 1;
    end
    if (t != 0 && u >= 0 && u < total) begin
      e.en  = 1'b1;
      e.clr = (u % nf == 0);
      e.ack = (u == total - 1);
    end
    if (t != 0 && u > 0 && u <= total && (u % nf == 0)) begin
      e.we  = 1'b1;
      e.idx = u / nf - 1;
    end
    e.valid = (t == total + lat + 2);
    return e;
  endfunction

  int t_a = 0;
  int t_b = 0;

  always @(posedge clk) begin
    t_a <= step(t_a, 26, 13, 1, rst, log_valid, mfcc_ready);
    t_b <= step(t_b, 1, 4, 3, rst, log_valid, mfcc_ready);
  end

  exp_t ea, eb;
  always @(negedge clk) begin
    if (chk_on) begin
      ea = model(t_a, 26, 13, 1);
      eb = model(t_b, 1, 4, 3);
      chk("a_log_ack",    int'(a_log_ack),    int'(ea.ack));
      chk("a_filt_idx",   int'(a_filt_idx),   ea.filt);
      chk("a_coef_addr",  int'(a_coef_addr),  ea.addr);
      chk("a_mac_en",     int'(a_mac_en),     int'(ea.en));
      chk("a_mac_clr",    int'(a_mac_clr),    int'(ea.clr));
      chk("a_res_we",     int'(a_res_we),     int'(ea.we));
      chk("a_res_idx",    int'(a_res_idx),    ea.idx);
      chk("a_mfcc_valid", int'(a_mfcc_valid), int'(ea.valid));
      chk("a_busy",       int'(a_busy),       int'(ea.busy));
      chk("b_log_ack",    int'(b_log_ack),    int'(eb.ack));
      chk("b_filt_idx",   int'(b_filt_idx),   eb.filt);
      chk("b_coef_addr",  int'(b_coef_addr),  eb.addr);
      chk("b_mac_en",     int'(b_mac_en),     int'(eb.en));
      chk("b_mac_clr",    int'(b_mac_clr),    int'(eb.clr));
      chk("b_res_we",     int'(b_res_we),     int'(eb.we));
      chk("b_res_idx",    int'(b_res_idx),    eb.idx);
      chk("b_mfcc_valid", int'(b_mfcc_valid), int'(eb.valid));
      chk("b_busy",       int'(b_busy),       int'(eb.busy));
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_outs"}, int'({a_log_ack, a_mac_en, a_mac_clr, a_res_we, a_mfcc_valid, a_busy}), 0);
    chk({tag, "_a_addr"}, int'(a_filt_idx) + int'(a_coef_addr) + int'(a_res_idx), 0);
    chk({tag, "_b_outs"}, int'({b_log_ack, b_mac_en, b_mac_clr, b_res_we, b_mfcc_valid, b_busy}), 0);
    chk({tag, "_b_addr"}, int'(b_filt_idx) + int'(b_coef_addr) + int'(b_res_idx), 0);
  endtask

  task automatic wait_a_valid(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (a_mfcc_valid) found = 1'b1;
    end
    chk({tag, "_valid_timeout"}, int'(found), 1);
  endtask

  initial begin
    int en_cnt, clr_cnt, we_cnt, ack_cnt, n;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    chk_on = 1'b1;

    // One frame, ready tied high; cycle 0 is the edge that takes log_valid
    @(negedge clk);
    log_valid = 1'b1;
    @(posedge clk);
    en_cnt = 0; clr_cnt = 0; we_cnt = 0;
    for (int c = 1; c <= 345; c++) begin
      @(negedge clk);
      if (c == 1) log_valid = 1'b0;
      en_cnt  += int'(a_mac_en);
      clr_cnt += int'(a_mac_clr);
      we_cnt  += int'(a_res_we);
      case (c)
        1:   begin chk("p1_en_c1", int'(a_mac_en), 0); chk("p1_busy_c1", int'(a_busy), 1); end
        2:   begin chk("p1_en_c2", int'(a_mac_en), 1); chk("p1_clr_c2", int'(a_mac_clr), 1); end
        3:   chk("p1_b_en_c3", int'(b_mac_en), 0);
        4:   begin chk("p1_b_en_c4", int'(b_mac_en), 1); chk("p1_b_clr_c4", int'(b_mac_clr), 1); end
        5:   begin chk("p1_b_we_c5", int'(b_res_we), 1); chk("p1_b_idx_c5", int'(b_res_idx), 0); end
        8:   begin chk("p1_b_we_c8", int'(b_res_we), 1); chk("p1_b_idx_c8", int'(b_res_idx), 3);
                   chk("p1_b_valid_c8", int'(b_mfcc_valid), 0); end
        9:   chk("p1_b_valid_c9", int'(b_mfcc_valid), 1);
        28:  begin chk("p1_we_c28", int'(a_res_we), 1); chk("p1_idx_c28", int'(a_res_idx), 0);
                   chk("p1_clr_c28", int'(a_mac_clr), 1); end
        338: begin chk("p1_addr_c338", int'(a_coef_addr), 337); chk("p1_filt_c338", int'(a_filt_idx), 25); end
        339: begin chk("p1_ack_c339", int'(a_log_ack), 1); chk("p1_en_c339", int'(a_mac_en), 1); end
        340: begin chk("p1_en_c340", int'(a_mac_en), 0); chk("p1_we_c340", int'(a_res_we), 1);
                   chk("p1_idx_c340", int'(a_res_idx), 12); chk("p1_valid_c340", int'(a_mfcc_valid), 0); end
        341: chk("p1_valid_c341", int'(a_mfcc_valid), 1);
        342: begin chk("p1_valid_c342", int'(a_mfcc_valid), 0); chk("p1_busy_c342", int'(a_busy), 0); end
        default: ;
      endcase
    end
    chk("p1_en_count", en_cnt, 338);
    chk("p1_clr_count", clr_cnt, 13);
    chk("p1_we_count", we_cnt, 13);

    // Backpressure with an ignored log_valid pulse while DONE
    mfcc_ready = 1'b0;
    log_valid = 1'b1;
    @(negedge clk);
    log_valid = 1'b0;
    wait_a_valid("bp");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_busy", int'(a_busy), 1);
      chk("bp_valid", int'(a_mfcc_valid), 1);
      if (i == 20) log_valid = 1'b1;
      if (i == 21) log_valid = 1'b0;
    end
    mfcc_ready = 1'b1;
    log_valid = 1'b1;
    @(negedge clk);
    chk("bp_idle_gap", int'(a_busy), 0);
    @(negedge clk);
    chk("bp_restart_busy", int'(a_busy), 1);
    chk("bp_restart_addr", int'(a_coef_addr), 0);
    log_valid = 1'b0;
    wait_a_valid("bp2");

    // Reset in the middle of RUN
    @(negedge clk);
    log_valid = 1'b1;
    @(negedge clk);
    log_valid = 1'b0;
    repeat (149) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    we_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      we_cnt  += int'(a_res_we);
      ack_cnt += int'(a_log_ack);
    end
    chk("midrst_no_we", we_cnt, 0);
    chk("midrst_no_ack", ack_cnt, 0);

    // Following frame keeps its timing
    log_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    log_valid = 1'b0;
    n = 1; found = 1'b0;
    while (!found && n < 1000) begin
      if (a_mfcc_valid) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("post_rst_valid_cycle", n, 341);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      log_valid  = ($urandom_range(0, 3) == 0);
      mfcc_ready = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 999) == 0);
    end
    rst = 1'b0;
    log_valid = 1'b0;
    mfcc_ready = 1'b1;
    repeat (400) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dct_sequencer.md
# dct_sequencer

Control sequencer for the time-multiplexed MFCC DCT-II datapath.
- Replaces the fully parallel 13×26 multiply-sum with a single shared multiply-accumulate (MAC) unit.
- Walks every (coefficient k, filter m) pair and drives the log-energy buffer read address and the coefficient ROM address.
- Issues MAC clear/enable and result write strobes, then hands the finished 13-coefficient vector downstream through a valid/ready handshake.
- Sits between the log-compression stage's frame buffer and the MFCC output register file; contains no arithmetic on data samples.

## Interface
Parameters:
- NUM_MFCC, 13, number of cepstral coefficients (k range)
- NUM_FILTERS, 26, number of mel filters (m range)
- ROM_LATENCY, 1, cycles from address issue to operand valid at MAC input (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- log_valid  in  1  level: a complete frame of log energies sits in the upstream buffer
- log_ack  out  1  one-cycle pulse: frame fully consumed, upstream may overwrite buffer
- filt_idx  out  $clog2(NUM_FILTERS)  log buffer read address m
- coef_addr  out  $clog2(NUM_MFCC*NUM_FILTERS)  ROM address k*NUM_FILTERS+m
- mac_en  out  1  MAC operands valid this cycle, accumulate
- mac_clr  out  1  with mac_en: load product instead of accumulating (first term of k)
- res_we  out  1  write MAC accumulator to result register res_idx
- res_idx  out  $clog2(NUM_MFCC)  result register index k
- mfcc_valid  out  1  level: all NUM_MFCC results written, held until accepted
- mfcc_ready  in  1  downstream accepts vector when high with mfcc_valid
- busy  out  1  high in any state other than IDLE

## Operation
FSM states:
- IDLE: wait for log_valid. Go to RUN next cycle, m=k=0.
- RUN: issue one address pair per cycle.
  - m increments, wrapping NUM_FILTERS-1→0 with k++.
  - coef_addr increments by 1 each cycle; no multiplier is used.
  - After the issue with k=NUM_MFCC-1, m=NUM_FILTERS-1, go to DRAIN.
- DRAIN: wait for the in-flight pipeline tags and the final res_we, then go to DONE.
- DONE: hold mfcc_valid=1. When mfcc_ready=1, go to IDLE next cycle.

Tag pipeline (ROM_LATENCY stages) carries {valid, first, last, k}:
- mac_en = delayed valid.
- mac_clr = delayed first (m==0).
- res_we asserts one cycle after a delayed last (m==NUM_FILTERS-1), with res_idx = that k.

Rules:
- log_ack pulses on the cycle of the final mac_en of the frame.
- log_valid is ignored outside IDLE; deasserting it mid-frame has no effect.
- mfcc_ready is ignored when mfcc_valid=0.
- NUM_FILTERS=1: first and last coincide, so mac_clr accompanies every mac_en and res_we follows every mac_en.
- filt_idx, coef_addr and res_idx return to 0 on entering DRAIN; they are don't-care outside RUN but are driven 0.

## Timing
- Reset: state IDLE, counters 0. All outputs 0: log_ack, filt_idx, coef_addr, mac_en, mac_clr, res_we, res_idx, mfcc_valid, busy.
- Reset in any state aborts the frame immediately, clearing the pipeline tags. No further res_we or log_ack is issued for that frame.
- Let T=NUM_MFCC*NUM_FILTERS and L=ROM_LATENCY, with log_valid seen in IDLE at cycle 0.
  - Issues occur on cycles 1..T.
  - mac_en is high on cycles 1+L..T+L.
  - res_we for k occurs on cycle (k+1)*NUM_FILTERS+L+1.
  - mfcc_valid rises on cycle T+L+2 (341 at defaults).
- Throughput: one MAC term per cycle, no bubbles within a frame.
- Minimum gap between frames: 1 IDLE cycle after acceptance.

## Structure
- Shared package dct_pkg holds:
  - NUM_MFCC, NUM_FILTERS, DATA_WIDTH, COEFF_WIDTH, COEFF_FRAC_BITS
  - derived address widths
  - the sequencer state enum (IDLE/RUN/DRAIN/DONE)
- Sub-module dct_tag_pipe: parameterised ROM_LATENCY-deep shift register for the tag bundle, with synchronous clear.

## Test plan
- Defaults, one frame, mfcc_ready tied 1:
  - mac_en high 338 consecutive cycles (2..339).
  - mac_clr on cycles 2, 28, …, 314.
  - res_we at 28, 54, …, 340 with res_idx 0..12.
  - log_ack at 339; mfcc_valid high for exactly 1 cycle at 341.
- Address sweep: coef_addr runs 0..337 monotonically and filt_idx repeats 0..25 thirteen times. Golden DCT model on the MAC bench matches all 13 outputs for log_in = ramp 0..25.
- Backpressure: hold mfcc_ready=0 for 50 cycles after valid. mfcc_valid stays 1 and busy stays 1. A log_valid pulse during this period is ignored; the new frame starts 1 cycle after IDLE.
- Reset injected at cycle 150 of RUN: next cycle all outputs 0. No res_we/log_ack afterwards; the following frame completes with correct timing.
- ROM_LATENCY=3, NUM_FILTERS=1, NUM_MFCC=4:
  - mac_en on cycles 4..7, each with mac_clr.
  - res_we on cycles 5..8.
  - mfcc_valid at 9.
